scurve_multi_channel_counter: RTL and testbench
===============================================

# scurve_multi_channel_counter

Parametrised multi-channel successor to the single-input S-curve counter, used in the SCurve test path of the SDHCAL DAQ FPGA. It counts injected pulses, taken as rising edges of `CLK_EXT`, and counts per-channel trigger falling edges after a programmable delay, for `N_CH` ASIC trigger lines in parallel. Counting runs in either trigger-efficiency or count-efficiency mode. A run-control state machine starts a test, stops at `CPT_MAX` pulses, waits for the last injection window to drain, and holds the results for slow-control readout.

## Interface
- `N_CH`, default 4: number of trigger channels.
- `CNT_W`, default 16: width of each counter and of `CPT_MAX`.
- `DLY_W`, default 4: width of `TriggerDelay`.
- `Clk` in 1: system clock. The block uses one clock. Reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `Test_Start` in 1: level. High runs a test; low aborts or re-arms.
- `TrigEffi_or_CountEffi` in 1: 1 selects trigger-efficiency mode, 0 selects count-efficiency mode.
- `CLK_EXT` in 1: asynchronous injection strobe. Its rising edge is one pulse.
- `Trigger` in `N_CH`: asynchronous, active-low trigger lines.
- `CPT_MAX` in `CNT_W`: number of pulses per test.
- `TriggerDelay` in `DLY_W`: trigger count delay, in `Clk` cycles.
- `CPT_PULSE` out `CNT_W`: pulse count.
- `CPT_TRIGGER` out `N_CH*CNT_W`: trigger counts. Channel i occupies bits `[i*CNT_W +: CNT_W]`.
- `CPT_DONE` out 1: high while in the DONE state.
- `Busy` out 1: high while in the COUNT or DRAIN state.

## Operation
- Synchronisers: `CLK_EXT` and each `Trigger` bit pass through a 2-FF chain. Edges are detected between the first and second stage.
- Reset values:
  - Synchroniser flops on `Trigger` reset to 1; all other synchroniser flops reset to 0.
  - All counters reset to 0; `CPT_DONE` and `Busy` reset to 0.
  - The state machine resets to IDLE.
- **IDLE**
  - Counters hold their values.
  - When `Test_Start` is 1: clear all counters and go to COUNT.
- **COUNT**
  - Each `CLK_EXT` rising edge increments `CPT_PULSE`.
  - Per channel, a delayed trigger-fall event increments that channel's `CPT_TRIGGER`.
  - If `Test_Start` is 0: go to IDLE. Counters hold their values and `CPT_DONE` stays 0.
  - If `CPT_PULSE >= CPT_MAX`: go to DRAIN. No further pulses are counted.
- **DRAIN**
  - Trigger counting continues.
  - Go to DONE on the first `CLK_EXT` falling edge observed with no channel delay pending.
  - If `Test_Start` is 0: go to IDLE.
- **DONE**
  - All counters are frozen and `CPT_DONE` is 1.
  - When `Test_Start` is 0: go to IDLE.
- Trigger delay, per channel:
  - A trigger fall loads a down-counter with `TriggerDelay`. The event fires when the counter reaches 0.
  - `TriggerDelay` = 0 fires on the cycle of detection.
  - Falls arriving while a delay is pending are ignored.
- Trigger-efficiency mode, per channel:
  - At most one trigger is counted per `CLK_EXT` high period.
  - The per-channel "seen" flag sets when an event fires. It clears on the synchronised `CLK_EXT` rising edge.
  - Falls detected while synchronised `CLK_EXT` is low are ignored.
- Count-efficiency mode: every delayed fall counts, independent of `CLK_EXT`.
- Arithmetic:
  - Counters are unsigned and saturate at all-ones; they never wrap.
  - A `CPT_MAX` of 0 causes entry to DRAIN on the first COUNT cycle with `CPT_PULSE` = 0.
- Simultaneous events: a pulse edge and a trigger event in the same cycle are both counted.

## Timing
- `CLK_EXT` rise captured at `Clk` edge k: `CPT_PULSE` updates at edge k+1.
- `Trigger` fall captured at edge k: `CPT_TRIGGER` updates at edge k+1+`TriggerDelay`.
- IDLE to COUNT: counters read 0 one cycle after `Test_Start` is sampled high.
- `CPT_DONE` rises one cycle after the qualifying `CLK_EXT` fall is detected. It falls one cycle after `Test_Start` is sampled low.
- Asynchronous reset mid-run: the block is in IDLE with all outputs 0 immediately, and restarts only on a `Test_Start` level sampled after reset release.

## Configuration
- Macro `SCURVE_OVF_FLAG_EN`.
- Defined: adds output `CPT_OVF` [`N_CH`+1]:
  - Bit `N_CH` is the sticky saturation flag for `CPT_PULSE`.
  - Bit i is the sticky saturation flag for `CPT_TRIGGER` channel i.
  - Flags clear on IDLE to COUNT and on reset.
- Undefined: the port is absent and saturation is silent.

## Test plan
- Count-efficiency, `N_CH`=4, `CPT_MAX`=100, 100 pulses, one trigger fall per pulse on channels 0 to 3, `TriggerDelay`=0: `CPT_PULSE`=100, every `CPT_TRIGGER`=100, `CPT_DONE`=1 after the 100th `CLK_EXT` fall.
- Trigger-efficiency, 3 falls per `CLK_EXT` high period on channel 1, plus 2 falls while `CLK_EXT` is low, over 10 pulses: channel 1 count = 10.
- `TriggerDelay`=5, single fall captured at edge k: the count increments exactly at edge k+6, and a second fall at edge k+2 is not counted.
- Trigger fall 3 cycles before the last `CLK_EXT` fall, `TriggerDelay`=7: the trigger is counted before `CPT_DONE` rises.
- `Test_Start` dropped after 40 of 100 pulses: state returns to IDLE, `CPT_PULSE`=40 holds, `CPT_DONE`=0. Reassert: counters restart from 0.
- `CNT_W`=4, count-efficiency, 20 triggers on channel 2: count saturates at 15 and, with `SCURVE_OVF_FLAG_EN` defined, `CPT_OVF[2]`=1.

Source files
------------

// File: rtl/scurve_multi_channel_counter.sv
// Multi-channel S-curve counter: counts CLK_EXT injection pulses and delayed
// per-channel trigger falls under a run-control FSM. Option: SCURVE_OVF_FLAG_EN adds CPT_OVF.
module scurve_multi_channel_counter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int DLY_W = 4
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  Test_Start,
  input  logic                  TrigEffi_or_CountEffi,
  input  logic                  CLK_EXT,
  input  logic [N_CH-1:0]       Trigger,
  input  logic [CNT_W-1:0]      CPT_MAX,
  input  logic [DLY_W-1:0]      TriggerDelay,
  output logic [CNT_W-1:0]      CPT_PULSE,
  output logic [N_CH*CNT_W-1:0] CPT_TRIGGER,
  output logic                  CPT_DONE,
  output logic                  Busy
`ifdef SCURVE_OVF_FLAG_EN
  ,
  output logic [N_CH:0]         CPT_OVF
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [1:0]                    state;
  logic [1:0]                    ext_pipe;
  logic                          ext_rise, ext_fall;
  logic                          busy, start, cnt_en, pulse_inc;
  logic [N_CH-1:0]               pend_vec;
  logic [N_CH-1:0][CNT_W-1:0]    trig_cnt;

  // ext_pipe[0] is the first sync stage; edges are taken between the stages
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) ext_pipe <= 2'b00;
    else          ext_pipe <= {ext_pipe[0], CLK_EXT};
  end

  assign ext_rise  = ext_pipe[0] & ~ext_pipe[1];
  assign ext_fall  = ~ext_pipe[0] & ext_pipe[1];
  assign busy      = (state == ST_COUNT) || (state == ST_DRAIN);
  assign start     = (state == ST_IDLE) && Test_Start;
  assign cnt_en    = busy && Test_Start;
  assign pulse_inc = (state == ST_COUNT) && Test_Start && (CPT_PULSE < CPT_MAX) && ext_rise;

  assign CPT_DONE    = (state == ST_DONE);
  assign Busy        = busy;
  assign CPT_TRIGGER = trig_cnt;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (Test_Start) state <= ST_COUNT;
        ST_COUNT: begin
          if (!Test_Start)               state <= ST_IDLE;
          else if (CPT_PULSE >= CPT_MAX) state <= ST_DRAIN;
        end
        // finish only once every channel's delayed event has landed
        ST_DRAIN: begin
          if (!Test_Start)                  state <= ST_IDLE;
          else if (ext_fall && !(|pend_vec)) state <= ST_DONE;
        end
        ST_DONE:  if (!Test_Start) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)                               CPT_PULSE <= '0;
    else if (start)                             CPT_PULSE <= '0;
    else if (pulse_inc && CPT_PULSE != CNT_SAT) CPT_PULSE <= CPT_PULSE + CNT_W'(1);
  end

`ifdef SCURVE_OVF_FLAG_EN
  logic            pulse_ovf;
  logic [N_CH-1:0] trig_ovf;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)                               pulse_ovf <= 1'b0;
    else if (start)                             pulse_ovf <= 1'b0;
    else if (pulse_inc && CPT_PULSE == CNT_SAT) pulse_ovf <= 1'b1;
  end

  assign CPT_OVF = {pulse_ovf, trig_ovf};
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    logic             t_s1, t_s2, pend, seen;
    logic             fall, accept, fire, count_ev, inc;
    logic [DLY_W-1:0] dcnt;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) {t_s2, t_s1} <= 2'b11;
      else          {t_s2, t_s1} <= {t_s1, Trigger[g]};
    end

    // in trigger-efficiency mode only falls inside the CLK_EXT high window arm the delay
    assign fall     = t_s2 & ~t_s1;
    assign accept   = busy & fall & ~pend & (~TrigEffi_or_CountEffi | ext_pipe[0]);
    assign fire     = (accept & (TriggerDelay == '0)) | (pend & (dcnt == DLY_W'(1)));
    assign count_ev = fire & (~TrigEffi_or_CountEffi | ~seen);
    assign inc      = cnt_en & count_ev;

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        pend <= 1'b0;
        dcnt <= '0;
      end else if (!busy) begin
        pend <= 1'b0;
      end else if (accept && TriggerDelay != '0) begin
        pend <= 1'b1;
        dcnt <= TriggerDelay;
      end else if (pend) begin
        dcnt <= dcnt - DLY_W'(1);
        if (dcnt == DLY_W'(1)) pend <= 1'b0;
      end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n)              seen <= 1'b0;
      else if (start | ext_rise) seen <= 1'b0;
      else if (fire)             seen <= 1'b1;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n)                  cnt <= '0;
      else if (start)                cnt <= '0;
      else if (inc && cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
    end

`ifdef SCURVE_OVF_FLAG_EN
    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n)                   trig_ovf[g] <= 1'b0;
      else if (start)                 trig_ovf[g] <= 1'b0;
      else if (inc && cnt == CNT_SAT) trig_ovf[g] <= 1'b1;
    end
`endif

    assign trig_cnt[g] = cnt;
    assign pend_vec[g] = pend;
  end

endmodule

// File: tb/tb_scurve_multi_channel_counter.sv
// Scoreboard bench: each run's final outputs are queued up front and checked by a
// monitor whenever Busy drops; cycle-exact points are checked inline.
module tb_scurve_multi_channel_counter;

  typedef struct {
    string       name;
    logic        done;
    logic [15:0] pulse;
    logic [63:0] trig;
  } exp_t;

  logic        Clk, reset_n, Test_Start, mode, CLK_EXT;
  logic [3:0]  Trigger;
  logic [15:0] cpt_max;
  logic [3:0]  dly;
  logic [15:0] CPT_PULSE;
  logic [63:0] CPT_TRIGGER;
  logic        CPT_DONE, Busy;
  logic [3:0]  cpt_max4;
  logic [3:0]  pulse4;
  logic [15:0] trig4;
  logic        done4, busy4;
`ifdef SCURVE_OVF_FLAG_EN
  logic [4:0]  ovf, ovf4;
`endif

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic busy_q = 1'b0;

  scurve_multi_channel_counter #(.N_CH(4), .CNT_W(16), .DLY_W(4)) dut (
    .Clk(Clk), .reset_n(reset_n), .Test_Start(Test_Start),
    .TrigEffi_or_CountEffi(mode), .CLK_EXT(CLK_EXT), .Trigger(Trigger),
    .CPT_MAX(cpt_max), .TriggerDelay(dly), .CPT_PULSE(CPT_PULSE),
    .CPT_TRIGGER(CPT_TRIGGER), .CPT_DONE(CPT_DONE), .Busy(Busy)
`ifdef SCURVE_OVF_FLAG_EN
    , .CPT_OVF(ovf)
`endif
  );

  scurve_multi_channel_counter #(.N_CH(4), .CNT_W(4), .DLY_W(4)) dut4 (
    .Clk(Clk), .reset_n(reset_n), .Test_Start(Test_Start),
    .TrigEffi_or_CountEffi(mode), .CLK_EXT(CLK_EXT), .Trigger(Trigger),
    .CPT_MAX(cpt_max4), .TriggerDelay(dly), .CPT_PULSE(pulse4),
    .CPT_TRIGGER(trig4), .CPT_DONE(done4), .Busy(busy4)
`ifdef SCURVE_OVF_FLAG_EN
    , .CPT_OVF(ovf4)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic push(input string name, input logic d, input logic [15:0] p, input logic [63:0] t);
    exp_t e;
    e.name = name; e.done = d; e.pulse = p; e.trig = t;
    exp_q.push_back(e);
  endtask

  task automatic ext_pulse(input int hi, input int lo);
    CLK_EXT = 1'b1; tick(hi);
    CLK_EXT = 1'b0; tick(lo);
  endtask

  task automatic trig_fall(input int ch);
    Trigger[ch] = 1'b0; tick(2);
    Trigger[ch] = 1'b1; tick(2);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && CPT_DONE !== 1'b1; i++) tick(1);
    chk(name, 64'(CPT_DONE), 64'd1);
  endtask

  task automatic abort_run();
    Test_Start = 1'b0; tick(2);
  endtask

  // Monitor: every end of a run (Busy falling) is matched against the queue
  always @(negedge Clk) begin
    exp_t e;
    if (busy_q && !Busy) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_run_end: got pulse %0d expected no run end", CPT_PULSE);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_done"},  64'(CPT_DONE),  64'(e.done));
        chk({e.name, "_pulse"}, 64'(CPT_PULSE), 64'(e.pulse));
        chk({e.name, "_trig"},  CPT_TRIGGER,    e.trig);
      end
    end
    busy_q <= Busy;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; Test_Start = 1'b0; mode = 1'b0; CLK_EXT = 1'b0;
    Trigger = 4'hF; cpt_max = 16'd100; cpt_max4 = 4'hF; dly = 4'd0;
    tick(2);
    chk("rst_pulse", 64'(CPT_PULSE), 64'd0);
    chk("rst_trig",  CPT_TRIGGER,    64'd0);
    chk("rst_done",  64'(CPT_DONE),  64'd0);
    chk("rst_busy",  64'(Busy),      64'd0);
    reset_n = 1'b1; tick(2);

    // 1: count-efficiency, 100 pulses, one fall per pulse on every channel
    push("ce100", 1'b1, 16'd100, 64'h0064_0064_0064_0064);
    Test_Start = 1'b1; tick(1);
    for (int i = 0; i < 100; i++) begin
      CLK_EXT = 1'b1; tick(2);
      Trigger = 4'h0; tick(2);
      Trigger = 4'hF; tick(2);
      CLK_EXT = 1'b0; tick(3);
    end
    wait_done("ce100_done_rise");
    abort_run();
    chk("idle_hold_pulse", 64'(CPT_PULSE), 64'd100);
    chk("idle_done_low",   64'(CPT_DONE),  64'd0);

    // 2: abort after 40 pulses, then restart clears counters
    Test_Start = 1'b1; tick(1);
    chk("start_clear_pulse", 64'(CPT_PULSE), 64'd0);
    chk("start_clear_trig",  CPT_TRIGGER,    64'd0);
    chk("start_busy",        64'(Busy),      64'd1);
    for (int i = 0; i < 40; i++) ext_pulse(3, 3);
    push("abort40", 1'b0, 16'd40, 64'd0);
    Test_Start = 1'b0; tick(3);
    chk("abort_hold_pulse", 64'(CPT_PULSE), 64'd40);
    chk("abort_done_low",   64'(CPT_DONE),  64'd0);
    Test_Start = 1'b1; tick(1);
    chk("restart_pulse", 64'(CPT_PULSE), 64'd0);
    push("restart", 1'b0, 16'd0, 64'd0);
    abort_run();

    // 3: trigger-efficiency, 3 falls high + 2 falls low per pulse on ch1
    mode = 1'b1; cpt_max = 16'd10;
    push("te10", 1'b1, 16'd10, 64'h0000_0000_000A_0000);
    Test_Start = 1'b1; tick(1);
    for (int i = 0; i < 10; i++) begin
      CLK_EXT = 1'b1; tick(2);
      repeat (3) trig_fall(1);
      CLK_EXT = 1'b0; tick(2);
      repeat (2) trig_fall(1);
      tick(1);
    end
    wait_done("te10_done_rise");
    abort_run();
    mode = 1'b0;

    // 4: delay 5, fall captured at edge k counts at k+6; fall at k+2 ignored
    cpt_max = 16'd100; dly = 4'd5;
    Test_Start = 1'b1; tick(1);
    Trigger[0] = 1'b0; tick(1);
    Trigger[0] = 1'b1; tick(1);
    Trigger[0] = 1'b0; tick(1);
    Trigger[0] = 1'b1; tick(3);
    chk("dly5_before", CPT_TRIGGER, 64'd0);
    tick(1);
    chk("dly5_at_k6", CPT_TRIGGER, 64'd1);
    tick(8);
    chk("dly5_second_ignored", CPT_TRIGGER, 64'd1);
    push("dly5", 1'b0, 16'd0, 64'd1);
    abort_run();

    // 5: delay 7, fall 3 cycles before last CLK_EXT fall; DONE waits for it
    dly = 4'd7; cpt_max = 16'd3;
    push("drain", 1'b1, 16'd3, 64'h0001_0000_0000_0000);
    Test_Start = 1'b1; tick(1);
    ext_pulse(3, 3); ext_pulse(3, 3);
    CLK_EXT = 1'b1; tick(3);
    Trigger[3] = 1'b0; tick(1);
    Trigger[3] = 1'b1; tick(2);
    CLK_EXT = 1'b0; tick(12);
    chk("drain_trig_counted", CPT_TRIGGER,   64'h0001_0000_0000_0000);
    chk("drain_not_done",     64'(CPT_DONE), 64'd0);
    ext_pulse(3, 3);
    wait_done("drain_done_rise");
    abort_run();

    // 6: saturation on a 4-bit instance, 20 falls on ch2
    dly = 4'd0; cpt_max = 16'd100;
    push("sat", 1'b0, 16'd0, 64'h0000_0014_0000_0000);
    Test_Start = 1'b1; tick(1);
    repeat (20) trig_fall(2);
    chk("sat_cnt4",       64'(trig4), 64'h0F00);
    chk("sat_busy4",      64'(busy4), 64'd1);
    chk("sat_done4",      64'(done4), 64'd0);
    chk("sat_pulse4",     64'(pulse4), 64'd0);
    chk("sat_cnt16",      CPT_TRIGGER, 64'h0000_0014_0000_0000);
`ifdef SCURVE_OVF_FLAG_EN
    chk("sat_ovf4",  64'(ovf4), 64'h04);
    chk("sat_ovf16", 64'(ovf),  64'h00);
`endif
    abort_run();

    // 7: CPT_MAX = 0 drains immediately, later pulse not counted
    cpt_max = 16'd0;
    push("max0", 1'b1, 16'd0, 64'd0);
    Test_Start = 1'b1; tick(2);
    chk("max0_busy", 64'(Busy), 64'd1);
    ext_pulse(3, 3);
    wait_done("max0_done_rise");
    abort_run();

    // 8: async reset mid-run, restart on Test_Start held high after release
    cpt_max = 16'd100;
    Test_Start = 1'b1; tick(1);
    repeat (5) ext_pulse(2, 2);
    push("reset_mid", 1'b0, 16'd0, 64'd0);
    reset_n = 1'b0; #1;
    chk("rst_mid_busy",  64'(Busy),      64'd0);
    chk("rst_mid_pulse", 64'(CPT_PULSE), 64'd0);
    chk("rst_mid_done",  64'(CPT_DONE),  64'd0);
    tick(2);
    reset_n = 1'b1; tick(1);
    chk("rst_restart_busy", 64'(Busy), 64'd1);
    push("post_reset", 1'b0, 16'd0, 64'd0);
    abort_run();

    tick(5);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
